// File: rtl/bilinear_pkg.sv
// Shared widths, fixed-point constants, FSM states and the coordinate payload
// carried down the bilinear coordinate pipeline.
package bilinear_pkg;

    localparam int unsigned COORD_WIDTH = 12;
    localparam int unsigned FIX_WIDTH   = 12;
    localparam int unsigned STEP_WIDTH  = COORD_WIDTH + FIX_WIDTH;
    localparam int unsigned ACC_WIDTH   = STEP_WIDTH + 1;
    localparam int unsigned PROD_WIDTH  = 2 * FIX_WIDTH;
    localparam int unsigned ONE         = 1 << FIX_WIDTH;
    localparam int unsigned HALF        = 1 << (FIX_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x0;
        logic [COORD_WIDTH-1:0] x1;
        logic [COORD_WIDTH-1:0] y0;
        logic [COORD_WIDTH-1:0] y1;
        logic [FIX_WIDTH-1:0]   fx;
        logic [FIX_WIDTH-1:0]   fy;
        logic                   last_col;
        logic                   last;
    } coord_t;

    // Source position of destination pixel 0: step/2 - 0.5 in signed Q format.
    function automatic logic signed [ACC_WIDTH-1:0] acc_init(input logic [STEP_WIDTH-1:0] step);
        return $signed({1'b0, step >> 1}) - $signed(ACC_WIDTH'(HALF));
    endfunction

endpackage

// File: rtl/bilinear_axis_map.sv
// One axis of the destination-to-source mapping: running accumulator (stage 1)
// followed by clamp and integer/fraction split (stage 2).
module bilinear_axis_map
    import bilinear_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   step_en_i,
    input  logic                   adv_i,
    input  logic [STEP_WIDTH-1:0]  step_i,
    input  logic [COORD_WIDTH-1:0] size_i,
    output logic [COORD_WIDTH-1:0] i0_o,
    output logic [COORD_WIDTH-1:0] i1_o,
    output logic [FIX_WIDTH-1:0]   frac_o
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic [COORD_WIDTH-1:0]      int_part;
    logic [COORD_WIDTH-1:0]      last_idx;

    assign int_part = acc[ACC_WIDTH-2 -: COORD_WIDTH];
    assign last_idx = size_i - COORD_WIDTH'(1);

    // Stage 1: source position of the coordinate just issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (load_i) begin
            acc <= acc_init(step_i);
        end else if (step_en_i) begin
            acc <= acc + $signed({1'b0, step_i});
        end
    end

    // Stage 2: clamp to the source edges, then split into neighbours and fraction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            i0_o   <= '0;
            i1_o   <= '0;
            frac_o <= '0;
        end else if (adv_i) begin
            if (acc[ACC_WIDTH-1]) begin
                i0_o   <= '0;
                i1_o   <= '0;
                frac_o <= '0;
            end else if (int_part >= last_idx) begin
                i0_o   <= last_idx;
                i1_o   <= last_idx;
                frac_o <= '0;
            end else begin
                i0_o   <= int_part;
                i1_o   <= int_part + COORD_WIDTH'(1);
                frac_o <= acc[FIX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/bilinear_coord_gen.sv
// Raster-scan destination walker producing source neighbour indices and
// bilinear weights through a 4-stage, backpressure-aware pipeline.
module bilinear_coord_gen
    import bilinear_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [COORD_WIDTH-1:0] src_w_i,
    input  logic [COORD_WIDTH-1:0] src_h_i,
    input  logic [COORD_WIDTH-1:0] dst_w_i,
    input  logic [COORD_WIDTH-1:0] dst_h_i,
    input  logic [STEP_WIDTH-1:0]  step_x_i,
    input  logic [STEP_WIDTH-1:0]  step_y_i,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic [COORD_WIDTH-1:0] x0_o,
    output logic [COORD_WIDTH-1:0] x1_o,
    output logic [COORD_WIDTH-1:0] y0_o,
    output logic [COORD_WIDTH-1:0] y1_o,
    output logic [FIX_WIDTH-1:0]   weight00_o,
    output logic [FIX_WIDTH-1:0]   weight01_o,
    output logic [FIX_WIDTH-1:0]   weight10_o,
    output logic [FIX_WIDTH-1:0]   weight11_o,
    output logic                   last_col_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o
);

    state_e state_q, state_d;

    logic [COORD_WIDTH-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [STEP_WIDTH-1:0]  step_x_q, step_y_q;
    logic [COORD_WIDTH-1:0] dx_q, dy_q;

    logic adv, accept, issue, row_end, last_coord;

    logic                   v1_q, lc1_q, l1_q;
    logic                   v2_q, lc2_q, l2_q;
    logic [COORD_WIDTH-1:0] x0_s2, x1_s2, y0_s2, y1_s2;
    logic [FIX_WIDTH-1:0]   fx_s2, fy_s2;
    logic                   v3_q;
    coord_t                 s3_q;
    logic [PROD_WIDTH-1:0]  prod_q;

    logic [FIX_WIDTH-1:0]   w11_c, w01_c, w10_c, w00_c;
    logic [FIX_WIDTH+1:0]   w00_full;

    assign adv        = ~m_tvalid_o | m_tready_i;
    assign accept     = (state_q == ST_IDLE) & start_i;
    assign issue      = (state_q == ST_RUN) & adv;
    assign row_end    = (dx_q == dst_w_q - COORD_WIDTH'(1));
    assign last_coord = row_end & (dy_q == dst_h_q - COORD_WIDTH'(1));
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (dst_w_i == '0 || dst_h_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_coord) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_tvalid_o && m_tready_i && last_o) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Frame configuration is frozen at the accepted start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_w_q  <= '0;
            src_h_q  <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
        end else if (accept) begin
            src_w_q  <= src_w_i;
            src_h_q  <= src_h_i;
            dst_w_q  <= dst_w_i;
            dst_h_q  <= dst_h_i;
            step_x_q <= step_x_i;
            step_y_q <= step_y_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (accept) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (issue) begin
            if (row_end) begin
                dx_q <= '0;
                dy_q <= dy_q + COORD_WIDTH'(1);
            end else begin
                dx_q <= dx_q + COORD_WIDTH'(1);
            end
        end
    end

    bilinear_axis_map u_axis_x (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (issue && dx_q == '0),
        .step_en_i (issue && dx_q != '0),
        .adv_i     (adv),
        .step_i    (step_x_q),
        .size_i    (src_w_q),
        .i0_o      (x0_s2),
        .i1_o      (x1_s2),
        .frac_o    (fx_s2)
    );

    bilinear_axis_map u_axis_y (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (issue && dx_q == '0 && dy_q == '0),
        .step_en_i (issue && dx_q == '0 && dy_q != '0),
        .adv_i     (adv),
        .step_i    (step_y_q),
        .size_i    (src_h_q),
        .i0_o      (y0_s2),
        .i1_o      (y1_s2),
        .frac_o    (fy_s2)
    );

    // Valid and flag tracking for stages 1-2; bubbles carry cleared flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q  <= 1'b0;
            lc1_q <= 1'b0;
            l1_q  <= 1'b0;
            v2_q  <= 1'b0;
            lc2_q <= 1'b0;
            l2_q  <= 1'b0;
        end else if (adv) begin
            v1_q  <= issue;
            lc1_q <= issue & row_end;
            l1_q  <= issue & last_coord;
            v2_q  <= v1_q;
            lc2_q <= lc1_q;
            l2_q  <= l1_q;
        end
    end

    // Stage 3: fraction product for the lower-right weight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v3_q   <= 1'b0;
            s3_q   <= '0;
            prod_q <= '0;
        end else if (adv) begin
            v3_q   <= v2_q;
            s3_q   <= '{x0: x0_s2, x1: x1_s2, y0: y0_s2, y1: y1_s2,
                        fx: fx_s2, fy: fy_s2, last_col: lc2_q, last: l2_q};
            prod_q <= PROD_WIDTH'(fx_s2) * PROD_WIDTH'(fy_s2);
        end
    end

    always_comb begin
        w11_c    = FIX_WIDTH'((prod_q + PROD_WIDTH'(HALF)) >> FIX_WIDTH);
        w01_c    = s3_q.fx - w11_c;
        w10_c    = s3_q.fy - w11_c;
        w00_full = (FIX_WIDTH+2)'(ONE) - (FIX_WIDTH+2)'(s3_q.fx)
                 - (FIX_WIDTH+2)'(s3_q.fy) + (FIX_WIDTH+2)'(w11_c);
        // 1.0 is not representable in FIX_WIDTH bits; clip the integer-aligned case.
        w00_c    = (w00_full == (FIX_WIDTH+2)'(ONE)) ? FIX_WIDTH'(ONE - 1)
                                                     : w00_full[FIX_WIDTH-1:0];
    end

    // Stage 4: output register, frozen while the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_tvalid_o <= 1'b0;
            x0_o       <= '0;
            x1_o       <= '0;
            y0_o       <= '0;
            y1_o       <= '0;
            weight00_o <= '0;
            weight01_o <= '0;
            weight10_o <= '0;
            weight11_o <= '0;
            last_col_o <= 1'b0;
            last_o     <= 1'b0;
        end else if (adv) begin
            m_tvalid_o <= v3_q;
            x0_o       <= s3_q.x0;
            x1_o       <= s3_q.x1;
            y0_o       <= s3_q.y0;
            y1_o       <= s3_q.y1;
            weight00_o <= w00_c;
            weight01_o <= w01_c;
            weight10_o <= w10_c;
            weight11_o <= w11_c;
            last_col_o <= s3_q.last_col;
            last_o     <= s3_q.last;
        end
    end

endmodule
